// File: rtl/fifo_pkg.sv
// Shared defaults and output-buffer state encoding for the dual-port-RAM stream FIFO.
// The encoding equals the number of words held, so the buffer count is the state itself.
package fifo_pkg;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;
endpackage

// File: rtl/dual_port_ram.sv
// 2^AW x DW dual-port RAM with registered reads; 1-cycle read latency, no flow control.
// Both clocks are tied together by the parent, so both write ports share the CLKA write path.
module dual_port_ram #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          CLKA,
  input  logic          WENA,
  input  logic [AW-1:0] AA,
  input  logic [DW-1:0] DA,
  input  logic          CLKB,
  input  logic          WENB,
  input  logic [AW-1:0] AB,
  input  logic [DW-1:0] DB,
  output logic [DW-1:0] QB
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge CLKA) begin
    if (WENA) begin
      r_mem[AA] <= DA;
    end else if (WENB) begin
      r_mem[AB] <= DB;
    end
  end

  always_ff @(posedge CLKB) begin
    QB <= r_mem[AB];
  end
endmodule

// File: rtl/out_skid2.sv
// 2-entry head/tail output buffer; 0-cycle load-to-head when empty or head pops without a tail.
// No internal backpressure: the parent only loads when a slot is guaranteed free.
module out_skid2 import fifo_pkg::*; #(
  parameter int DW = fifo_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_dat,
  input  logic          i_pop,
  output logic [1:0]    o_cnt,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);
  buf_state_e    r_state, w_state_nxt;
  logic [DW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      EMPTY: begin
        if (i_load) begin
          w_head_nxt  = i_load_dat;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        case ({i_load, i_pop})
          2'b11: w_head_nxt = i_load_dat;
          2'b01: w_state_nxt = EMPTY;
          2'b10: begin
            w_tail_nxt  = i_load_dat;
            w_state_nxt = TWO;
          end
          default: ;
        endcase
      end
      TWO: begin
        // A load into a full buffer without a pop cannot occur: issue is gated on free space.
        if (i_pop) begin
          w_head_nxt = r_tail;
          if (i_load) w_tail_nxt = i_load_dat;
          else        w_state_nxt = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  assign o_cnt = r_state;
  assign o_vld = (r_state != EMPTY);
  assign o_dat = r_head;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO over a 32x8 registered-read RAM; empty-to-output latency 3 cycles, then 1 word/cycle.
// IN_READY drops when the RAM holds DEPTH words; OUT_DATA holds while OUT_VALID & !OUT_READY.
module dpram_fifo_ctrl import fifo_pkg::*; #(
  parameter int DW       = fifo_pkg::DW,
  parameter int AW       = fifo_pkg::AW,
  parameter int DEPTH    = fifo_pkg::DEPTH,
  parameter int AF_LEVEL = 28
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic [AW:0]   COUNT,
  output logic          ALMOST_FULL,
  output logic          WENA,
  output logic [AW-1:0] AA,
  output logic [DW-1:0] DA,
  output logic          WENB,
  output logic [AW-1:0] AB,
  input  logic [DW-1:0] QB
);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF    = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_inflight;
  logic          w_push, w_pop, w_issue;
  logic [1:0]    w_buf_cnt;
  logic [2:0]    w_occ;

  assign IN_READY = RSTN & (r_ram_cnt != C_DEPTH);
  assign w_push   = IN_VALID & IN_READY;
  assign w_pop    = OUT_VALID & OUT_READY;

  // Buffer slots still claimed after this cycle's pop; a read may issue only into a free one.
  assign w_occ   = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_ram_cnt != '0) & (w_occ < 3'd2);

  assign WENA = w_push;
  assign AA   = r_wr_ptr;
  assign DA   = RSTN ? IN_DATA : '0;
  assign WENB = 1'b0;
  assign AB   = r_rd_ptr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_inflight <= w_issue;
      case ({w_push, w_issue})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
    end
  end

  assign COUNT       = r_ram_cnt + (AW+1)'(r_inflight) + (AW+1)'(w_buf_cnt);
  assign ALMOST_FULL = (COUNT >= C_AF);

  out_skid2 #(.DW(DW)) u_out_skid2 (
    .i_clk      (CLK),
    .i_rst_n    (RSTN),
    .i_load     (r_inflight),
    .i_load_dat (QB),
    .i_pop      (w_pop),
    .o_cnt      (w_buf_cnt),
    .o_vld      (OUT_VALID),
    .o_dat      (OUT_DATA)
  );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl driving a dual_port_ram model; scoreboard queue fed on accept,
// independent monitor checks every output transfer, hold-while-stalled and the COUNT ceiling.
module tb_dpram_fifo_ctrl;
  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       OUT_READY = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY, OUT_VALID, ALMOST_FULL, WENA, WENB;
  logic [7:0] OUT_DATA, DA, QB;
  logic [5:0] COUNT;
  logic [4:0] AA, AB;

  int         total = 0;
  int         bad = 0;
  int         n_out = 0;
  logic [7:0] q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  always #5 CLK = ~CLK;

  dpram_fifo_ctrl dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL),
    .WENA(WENA), .AA(AA), .DA(DA), .WENB(WENB), .AB(AB), .QB(QB)
  );

  dual_port_ram ram (
    .CLKA(CLK), .WENA(WENA), .AA(AA), .DA(DA),
    .CLKB(CLK), .WENB(WENB), .AB(AB), .DB(8'h00), .QB(QB)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTN && IN_VALID && IN_READY) q.push_back(IN_DATA);
  end

  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_stall <= 1'b0;
    end else begin
      total++;
      if (COUNT > 6'd34) begin
        bad++;
        $display("FAIL count_max: got %0d expected <= 34", COUNT);
      end
      if (prev_stall && OUT_VALID) chk("hold", {24'h0, OUT_DATA}, {24'h0, prev_dat});
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got %0h expected no output", OUT_DATA);
        end else begin
          chk("out_data", {24'h0, OUT_DATA}, {24'h0, q.pop_front()});
        end
        n_out <= n_out + 1;
      end
      prev_stall <= OUT_VALID && !OUT_READY;
      prev_dat   <= OUT_DATA;
    end
  end

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    @(posedge CLK); #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #1;
      if (q.size() == 0 && !OUT_VALID) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, q.size());
    end
    chk({name, "_count"}, {26'h0, COUNT}, 32'd0);
    OUT_READY = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int sent;

    // Reset values, with upstream offering a word to prove nothing leaks through
    IN_VALID = 1'b1;
    IN_DATA  = 8'h5A;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_af", ALMOST_FULL, 0);
    chk("rst_wena", WENA, 0);
    chk("rst_aa", AA, 0);
    chk("rst_da", DA, 0);
    chk("rst_wenb", WENB, 0);
    chk("rst_ab", AB, 0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    RSTN = 1'b1;
    #1 chk("rel_in_ready", IN_READY, 1);

    // Single word latency: accept in cycle 0, OUT_VALID in cycle 3
    for (int c = 0; c <= 4; c++) begin
      @(posedge CLK); #1;
      IN_VALID  = (c == 0);
      IN_DATA   = 8'h11;
      OUT_READY = (c == 3);
      @(negedge CLK);
      if (c == 0) begin
        chk("t1_wena", WENA, 1);
        chk("t1_aa", AA, 0);
        chk("t1_da", DA, 8'h11);
        chk("t1_count0", COUNT, 0);
      end else if (c < 3) begin
        chk("t1_vld_early", OUT_VALID, 0);
        chk("t1_count", COUNT, 1);
        chk("t1_ab", AB, c - 1);
      end else if (c == 3) begin
        chk("t1_vld", OUT_VALID, 1);
        chk("t1_data", OUT_DATA, 8'h11);
        chk("t1_count3", COUNT, 1);
      end else begin
        chk("t1_vld_after", OUT_VALID, 0);
        chk("t1_count_after", COUNT, 0);
      end
    end

    // Fill to capacity with the output stalled
    n0 = n_out;
    for (int k = 0; k <= 34; k++) begin
      @(posedge CLK); #1;
      IN_VALID = (k < 34);
      IN_DATA  = 8'(k);
      @(negedge CLK);
      chk("fill_in_ready", IN_READY, (k < 34));
      chk("fill_count", COUNT, k);
      chk("fill_af", ALMOST_FULL, (k >= 28));
    end
    drain("fill_drain");
    chk("fill_n_out", n_out - n0, 34);

    // Continuous stream; pointers start at 3 (35 words written so far) and wrap
    n0 = n_out;
    for (int c = 0; c <= 102; c++) begin
      @(posedge CLK); #1;
      IN_VALID  = (c < 100);
      IN_DATA   = 8'(c + 8'h40);
      OUT_READY = 1'b1;
      @(negedge CLK);
      if (c < 100) begin
        chk("strm_in_ready", IN_READY, 1);
        chk("strm_aa", AA, (3 + c) % 32);
      end
      if (c <= 100) chk("strm_ab", AB, (3 + ((c > 0) ? c - 1 : 0)) % 32);
      if (c >= 3) chk("strm_no_bubble", OUT_VALID, 1);
    end
    drain("strm_drain");
    chk("strm_n_out", n_out - n0, 100);

    // Random valid/ready, 1000 accepted words
    n0 = n_out;
    sent = 0;
    for (int i = 0; i < 20000 && sent < 1000; i++) begin
      @(posedge CLK); #1;
      IN_VALID  = 1'($urandom_range(0, 1));
      IN_DATA   = 8'($urandom);
      OUT_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (IN_VALID && IN_READY) sent++;
    end
    chk("rand_sent", sent, 1000);
    drain("rand_drain");
    chk("rand_n_out", n_out - n0, 1000);

    // Reset with COUNT = 10 and a read in flight
    for (int k = 0; k <= 11; k++) begin
      @(posedge CLK); #1;
      IN_VALID  = (k <= 10);
      IN_DATA   = 8'(8'h60 + k);
      OUT_READY = (k == 10);
      @(negedge CLK);
    end
    chk("mid_count", COUNT, 10);
    #1 RSTN = 1'b0;
    #1;
    q.delete();
    chk("mid_out_valid", OUT_VALID, 0);
    chk("mid_out_data", OUT_DATA, 0);
    chk("mid_count_rst", COUNT, 0);
    chk("mid_in_ready", IN_READY, 0);
    chk("mid_aa", AA, 0);
    chk("mid_ab", AB, 0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(posedge CLK); #1;
      IN_VALID = (c == 0);
      IN_DATA  = 8'hA5;
      @(negedge CLK);
      if (c < 3) chk("post_rst_vld_early", OUT_VALID, 0);
    end
    chk("post_rst_vld", OUT_VALID, 1);
    chk("post_rst_data", OUT_DATA, 8'hA5);
    chk("post_rst_count", COUNT, 1);

    // Simultaneous push and pop at COUNT = 1
    @(posedge CLK); #1;
    IN_VALID  = 1'b1;
    IN_DATA   = 8'h3C;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("pp_count", COUNT, 1);
    @(posedge CLK); #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("pp_count_next", COUNT, 1);
    chk("pp_vld_gap", OUT_VALID, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (OUT_VALID) break;
    end
    chk("pp_vld", OUT_VALID, 1);
    chk("pp_data", OUT_DATA, 8'h3C);
    chk("pp_count_held", COUNT, 1);
    drain("pp_drain");
    chk("pp_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that turns the 32×8 `dual_port_ram` into a valid/ready stream FIFO.
- It sits directly upstream of the RAM and drives both of its ports.
  - Port A is write-only.
  - Port B is read-only.
- A 2-entry output buffer absorbs the RAM's registered read latency, giving bubble-free one-word-per-cycle streaming.
- The parent ties the RAM's `CLKA` and `CLKB` to `CLK`.

## Interface
- `DW`, 8, data width
- `AW`, 5, RAM address width
- `DEPTH`, 32, RAM entries (must equal 2^AW)
- `AF_LEVEL`, 28, total occupancy at or above which `ALMOST_FULL` asserts

Ports:
- `CLK`  in  1  single clock for all logic
- `RSTN`  in  1  reset (one clock; reset is asynchronous and active-low)
- `IN_VALID`  in  1  upstream word offered
- `IN_READY`  out  1  FIFO accepts word
- `IN_DATA`  in  DW  upstream word
- `OUT_VALID`  out  1  head word available
- `OUT_READY`  in  1  downstream takes head word
- `OUT_DATA`  out  DW  head word
- `COUNT`  out  6  total words held (RAM + in-flight + buffer), 0..DEPTH+2
- `ALMOST_FULL`  out  1  `COUNT >= AF_LEVEL`
- `WENA`  out  1  RAM port-A write enable
- `AA`  out  AW  RAM port-A address
- `DA`  out  DW  RAM port-A write data
- `WENB`  out  1  RAM port-B write enable, constant 0
- `AB`  out  AW  RAM port-B read address
- `QB`  in  DW  RAM port-B read data, valid one cycle after `AB` is sampled

## Operation
**Write side**
- `push = IN_VALID & IN_READY`.
- `IN_READY = RSTN & (ram_cnt != DEPTH)`.
- `WENA = push`, `AA = wr_ptr`, `DA = IN_DATA`, all combinational.
- `wr_ptr` increments mod DEPTH on push.

**Read issue**
- `AB = rd_ptr` at all times.
- Let `pop = OUT_VALID & OUT_READY`.
- A read issues in a cycle iff `ram_cnt > 0` and `buf_cnt + inflight - pop < 2`.
- On issue: `rd_ptr` increments mod DEPTH, and `inflight` is set for the next cycle.
- While `inflight` is 1, `QB` is loaded into the buffer at the next edge.

**Counters**
- `ram_cnt` is 0..32 (6 bits): +1 on push, -1 on issue, unchanged when both occur.
- `COUNT = ram_cnt + inflight + buf_cnt`.

**Output buffer** (`out_skid2`)
- States: `EMPTY` (0 words), `ONE` (head only), `TWO` (head + tail).
- `OUT_VALID = (state != EMPTY)`; `OUT_DATA` is the head register.
- Load and pop rules:
  - Incoming `QB` goes to the head if the buffer is empty or the head is popping with no tail; otherwise it goes to the tail.
  - On pop in `TWO`, tail moves to head.
- Word order is strictly FIFO.

**Boundary conditions**
- Full (`ram_cnt == 32`): `IN_READY = 0`. A push and an issue in the same cycle is legal only when not full.
- Empty RAM with a free buffer slot: no issue.
  - A word pushed at edge t is readable (issued) in cycle t+1 at the earliest.
  - Ports A and B therefore never address the same entry in the same cycle with stale data.
- Pointer wrap: 31 → 0 with no gap.
- Reset mid-operation: all pointers, counters, `inflight` and the buffer clear immediately. In-flight data is discarded.

## Timing
- **Reset values:**
  - `IN_READY` = 0.
  - `OUT_VALID`, `OUT_DATA`, `COUNT`, `ALMOST_FULL`, `WENA`, `AA`, `DA`, `WENB`, `AB` = 0.
  - `IN_READY` becomes 1 combinationally once `RSTN` rises.
- **Empty-to-output latency:**
  - push accepted in cycle 0
  - read issued in cycle 1
  - `QB` valid in cycle 2
  - `OUT_VALID` = 1 in cycle 3
- **Steady state:** with `OUT_READY` held high and `IN_VALID` continuous, one word per cycle in and out.
- **Output hold:** `OUT_DATA` is stable while `OUT_VALID & !OUT_READY`.
- **Capacity:** maximum `COUNT` = 34. `IN_READY` deasserts when RAM holds 32 words, regardless of buffer state.

## Structure
- Shared package `fifo_pkg`:
  - `DW`, `AW`, `DEPTH` defaults
  - buffer state encoding `EMPTY`=0, `ONE`=1, `TWO`=2
- One sub-module, `out_skid2`: the 2-entry output buffer.
  - Inputs: load strobe, load data, pop.
  - Outputs: `buf_cnt`, `OUT_VALID`, `OUT_DATA`.
- Top level holds pointers, counters, issue logic and the RAM port drive.
- The testbench instantiates `dual_port_ram` alongside the controller.

## Test plan
- Reset, then push 0x11: `OUT_VALID` rises exactly 3 cycles after the accept; `OUT_DATA` = 0x11; `COUNT` goes 1 → 1 → 1 → 0 after the pop.
- Push 34 words 0x00..0x21 with `OUT_READY` = 0:
  - `IN_READY` drops after the 34th accept.
  - `COUNT` = 34, `ALMOST_FULL` = 1 from `COUNT` = 28.
  - Drain returns 0x00..0x21 in order.
- Continuous stream of 100 incrementing words with both sides always ready: after the 3-cycle fill there are no bubbles; output equals input; `AA`/`AB` wrap 31 → 0 cleanly.
- Random `IN_VALID`/`OUT_READY` (50%) over 1000 words: scoreboard matches; `COUNT` never exceeds 34; `OUT_DATA` is stable while stalled.
- Assert `RSTN` low with `COUNT` = 10 and a read in flight: all outputs are 0 immediately; after release the first new word 0xA5 comes out with no stale data.
- Simultaneous push and pop at `COUNT` = 1: `COUNT` stays 1; the next output is the newly pushed word.
